bsnn_spike_encoder: RTL
=======================

Name: bsnn_spike_encoder

Overview:
- Rate-coded spike source for the binary SNN layer: converts one frame of N_CH unsigned intensity values into T_STEPS timesteps of binary spike vectors.
- Its spike_out bus drives the spike_in inputs of the LIF neuron array.
- Sits between the sample-load interface (ready/valid) and the neuron layer; steps in lockstep with the layer via step_en.
- Default mode is deterministic first-order delta-sigma (phase accumulator) encoding.

Parameters:
- N_CH, 4, number of channels (spike lanes); must be ≥1.
- VAL_WIDTH, 4, bits per intensity value; legal range 4..8.
- T_STEPS, 16, timesteps per frame; must be ≥1. The step counter is $clog2(T_STEPS) bits wide, minimum 1.
- LFSR_SEED, 1, nonzero LFSR reset value; used only with BSNN_LFSR_EN.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- nRST  in  1  asynchronous, active-low reset.
- in_valid  in  1  frame values present on in_data.
- in_ready  out  1  encoder can accept a frame. High only in IDLE; decoded from the state register, not from inputs.
- in_data  in  N_CH*VAL_WIDTH  channel i is in_data[i*VAL_WIDTH +: VAL_WIDTH].
- step_en  in  1  layer advance strobe; one timestep is emitted per cycle in RUN while step_en=1.
- spike_out  out  N_CH  registered spike vector, one bit per channel.
- spike_valid  out  1  spike_out holds a timestep (1-cycle pulse per timestep).
- frame_start  out  1  1-cycle pulse after a frame load; used to clear neuron membranes.
- frame_done  out  1  1-cycle pulse coincident with the last timestep of a frame.
- busy  out  1  state==RUN.

Behaviour:
- Reset (async, nRST=0):
  - state=IDLE; val regs, accumulators and step_cnt cleared.
  - spike_out, spike_valid, frame_start and frame_done all 0.
  - in_ready=1 while nRST=1 and state is IDLE.
- States:
  - IDLE: in_ready=1. When in_valid && in_ready, latch in_data into val[i], clear acc[i] and step_cnt, go to RUN. frame_start=1 on the following cycle.
  - RUN: in_ready=0; in_valid is ignored and no data is latched.
    - Cycle with step_en=1:
      - sum[i] = {1'b0, acc[i]} + {1'b0, val[i]}, VAL_WIDTH+1 bits.
      - acc[i] <= sum[i][VAL_WIDTH-1:0] (wraps modulo 2^VAL_WIDTH).
      - spike_out[i] <= sum[i][VAL_WIDTH] (the carry).
      - spike_valid <= 1; step_cnt++.
    - If step_cnt==T_STEPS-1 on that step: frame_done <= 1 and state <= IDLE on the same edge.
    - Cycle with step_en=0: acc and step_cnt hold; spike_out <= 0; spike_valid <= 0. A stall never emits a spike.
- Outputs outside an accepted step: spike_out=0 and spike_valid=0 in every cycle that does not follow an accepted step, including all of IDLE.
- Latency:
  - Step accepted at edge k → spike_out/spike_valid visible after edge k.
  - Frame accepted → first step can be accepted on the very next edge.
  - Earliest back-to-back frame: in_ready returns the cycle after frame_done is asserted.
- Spike count: with T_STEPS = 2^VAL_WIDTH, channel i emits exactly val[i] spikes per frame.
  - val=0 → none.
  - val=2^VAL_WIDTH-1 → every step except the first.
- Simultaneous events: frame_start and the first spike_valid may coincide (step_en=1 on the cycle right after load). The layer must treat frame_start as taking precedence.
- T_STEPS=1: the load is followed by a single step, and that step asserts frame_done.
- Reset mid-frame: aborts immediately. No frame_done is issued and the partial frame is discarded.

Optional Feature:
- BSNN_LFSR_EN defined → stochastic encoding.
  - Maximal-length Fibonacci LFSR of VAL_WIDTH bits. Taps:
    - 4: x^4+x^3+1
    - 5: x^5+x^3+1
    - 6: x^6+x^5+1
    - 7: x^7+x^6+1
    - 8: x^8+x^6+x^5+x^4+1
  - Reset value is LFSR_SEED. The LFSR advances only on accepted steps and is not reseeded on frame load.
  - spike_out[i] <= (val[i] > rotl(lfsr, i mod VAL_WIDTH)).
  - Accumulators are not instantiated. Handshake and timing are unchanged.
- Undefined → delta-sigma accumulator as above; no LFSR logic.

Test Plan:
- in_data={ch3..ch0}={0,1,8,15}, T_STEPS=16, step_en held 1 → per-channel counts 0/1/8/15.
  - ch1 (val 8) spikes on odd steps only.
  - ch2 (val 1) spikes only on step 15.
  - frame_done coincides with step 15's spike_valid.
- Same frame with step_en toggling 1,0,1,0… → identical spike sequence spread over 32 cycles; spike_out=0 and spike_valid=0 on every stall cycle.
- in_valid held 1 during RUN with changing in_data → in_ready=0 and spikes reflect only the first frame. Second frame accepted the cycle after frame_done; frame_start pulses once per load.
- nRST pulsed low at step 7 → outputs 0 immediately (async) with no frame_done; after release, in_ready=1 and a new frame encodes from acc=0.
- T_STEPS=1, val=15 → one spike_valid with spike_out=0, and frame_done asserted on the same cycle.
- BSNN_LFSR_EN, seed=1, vals {0,15,15,15} over 15 steps → ch0 emits 0 spikes; the other channels match a bit-accurate model of the LFSR sequence (14 spikes each).

Source files
------------

// File: rtl/bsnn_spike_encoder_if.sv
// Sample-load handshake for the spike encoder: one frame of N_CH packed
// intensity values, transferred with valid/ready.
interface bsnn_spike_encoder_if #(
    parameter int N_CH      = 4,
    parameter int VAL_WIDTH = 4
);
    logic                      in_valid;
    logic                      in_ready;
    logic [N_CH*VAL_WIDTH-1:0] in_data;

    // Frame source (sample loader / testbench)
    modport master (
        output in_valid,
        output in_data,
        input  in_ready
    );

    // Frame sink (the encoder)
    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready
    );
endinterface

// File: rtl/bsnn_spike_encoder.sv
// Rate-coded spike source for the binary SNN layer.
// Loads one frame of N_CH unsigned intensities, then emits T_STEPS binary
// spike vectors, one per cycle in which step_en is high.
// Default encoding: first-order delta-sigma (per-channel phase accumulator,
// spike = accumulator carry).
// Optional macro BSNN_LFSR_EN: stochastic encoding against a shared
// maximal-length Fibonacci LFSR instead of accumulators.
module bsnn_spike_encoder #(
    parameter int N_CH      = 4,
    parameter int VAL_WIDTH = 4,
    parameter int T_STEPS   = 16,
    parameter int LFSR_SEED = 1
) (
    input  logic                CLK,
    input  logic                nRST,
    bsnn_spike_encoder_if.slave load,
    input  logic                step_en,
    output logic [N_CH-1:0]     spike_out,
    output logic                spike_valid,
    output logic                frame_start,
    output logic                frame_done,
    output logic                busy
);

    localparam int CNT_W = (T_STEPS > 1) ? $clog2(T_STEPS) : 1;
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(T_STEPS - 1);

    // Elaboration-time parameter legality
    if (N_CH < 1) begin : g_bad_n_ch
        $error("bsnn_spike_encoder: N_CH must be >= 1");
    end
    if (VAL_WIDTH < 4 || VAL_WIDTH > 8) begin : g_bad_val_width
        $error("bsnn_spike_encoder: VAL_WIDTH must be in 4..8");
    end
    if (T_STEPS < 1) begin : g_bad_t_steps
        $error("bsnn_spike_encoder: T_STEPS must be >= 1");
    end
    if ((LFSR_SEED % (2 ** VAL_WIDTH)) == 0) begin : g_bad_seed
        $error("bsnn_spike_encoder: LFSR_SEED must be nonzero in VAL_WIDTH bits");
    end

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t               state;
    logic [VAL_WIDTH-1:0] val [N_CH];
    logic [CNT_W-1:0]     step_cnt;
    logic [N_CH-1:0]      spike_next;

    assign load.in_ready = (state == IDLE);
    assign busy          = (state == RUN);

`ifdef BSNN_LFSR_EN
    logic [VAL_WIDTH-1:0] lfsr;
    logic [VAL_WIDTH-1:0] lfsr_next;
    logic                 fb;
    logic [VAL_WIDTH-1:0] rot [N_CH];

    // Feedback taps for the maximal-length polynomial of this width
    if (VAL_WIDTH == 4) begin : g_tap4
        assign fb = lfsr[3] ^ lfsr[2];
    end else if (VAL_WIDTH == 5) begin : g_tap5
        assign fb = lfsr[4] ^ lfsr[2];
    end else if (VAL_WIDTH == 6) begin : g_tap6
        assign fb = lfsr[5] ^ lfsr[4];
    end else if (VAL_WIDTH == 7) begin : g_tap7
        assign fb = lfsr[6] ^ lfsr[5];
    end else begin : g_tap8
        assign fb = lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3];
    end

    assign lfsr_next = {lfsr[VAL_WIDTH-2:0], fb};

    // Per-channel comparison against a channel-specific rotation of the LFSR
    always_comb begin
        spike_next = '0;
        rot        = '{default: '0};
        for (int unsigned i = 0; i < N_CH; i++) begin
            rot[i] = (lfsr << (i % VAL_WIDTH)) | (lfsr >> (VAL_WIDTH - (i % VAL_WIDTH)));
            spike_next[i] = (val[i] > rot[i]);
        end
    end
`else
    logic [VAL_WIDTH-1:0] acc      [N_CH];
    logic [VAL_WIDTH-1:0] acc_next [N_CH];
    logic [VAL_WIDTH:0]   sum      [N_CH];

    // Delta-sigma step: add intensity to phase, carry out is the spike
    always_comb begin
        spike_next = '0;
        sum        = '{default: '0};
        acc_next   = '{default: '0};
        for (int unsigned i = 0; i < N_CH; i++) begin
            sum[i]        = {1'b0, acc[i]} + {1'b0, val[i]};
            acc_next[i]   = sum[i][VAL_WIDTH-1:0];
            spike_next[i] = sum[i][VAL_WIDTH];
        end
    end
`endif

    // Frame FSM with registered spike/strobe outputs; outputs default to 0
    // so stalls and IDLE never show a spike
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state       <= IDLE;
            step_cnt    <= '0;
            spike_out   <= '0;
            spike_valid <= 1'b0;
            frame_start <= 1'b0;
            frame_done  <= 1'b0;
            for (int unsigned i = 0; i < N_CH; i++) begin
                val[i] <= '0;
`ifndef BSNN_LFSR_EN
                acc[i] <= '0;
`endif
            end
`ifdef BSNN_LFSR_EN
            lfsr <= VAL_WIDTH'(LFSR_SEED);
`endif
        end else begin
            spike_out   <= '0;
            spike_valid <= 1'b0;
            frame_start <= 1'b0;
            frame_done  <= 1'b0;
            case (state)
                IDLE: begin
                    if (load.in_valid) begin
                        for (int unsigned i = 0; i < N_CH; i++) begin
                            val[i] <= load.in_data[i*VAL_WIDTH +: VAL_WIDTH];
`ifndef BSNN_LFSR_EN
                            acc[i] <= '0;
`endif
                        end
                        step_cnt    <= '0;
                        frame_start <= 1'b1;
                        state       <= RUN;
                    end
                end
                RUN: begin
                    if (step_en) begin
                        spike_out   <= spike_next;
                        spike_valid <= 1'b1;
                        step_cnt    <= step_cnt + CNT_W'(1);
`ifdef BSNN_LFSR_EN
                        lfsr <= lfsr_next;
`else
                        for (int unsigned i = 0; i < N_CH; i++) begin
                            acc[i] <= acc_next[i];
                        end
`endif
                        if (step_cnt == LAST_STEP) begin
                            frame_done <= 1'b1;
                            state      <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
